// File: rtl/chk_axis_rx_if.sv
// Purpose: 64-bit RX AXI4-Stream beat bundle from the 10G MAC into the checker.
// Latency: none, wires only.
// Backpressure: none, there is no tready and every valid beat is consumed.
interface chk_axis_rx_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tlast;
   logic        tuser;

   modport master (
      output tdata,
      output tkeep,
      output tvalid,
      output tlast,
      output tuser
   );

   modport slave (
      input tdata,
      input tkeep,
      input tvalid,
      input tlast,
      input tuser
   );
endinterface

// File: rtl/chk_axis_rx.sv
// Purpose: reassembles RX AXIS frames, checks tkeep framing and length, counts good/bad/err, issues end-of-test verdict.
// Latency: counters update 1 cycle after the tlast beat; verdict 1 cycle after the drain exit condition holds.
// Backpressure: none; every valid beat is consumed, full-rate back-to-back frames supported.
module chk_axis_rx #(
   parameter int MIN_LEN      = 64,
   parameter int MAX_LEN      = 1518,
   parameter int IDLE_TIMEOUT = 1000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rx_dcm_locked,
   input  logic         rx_axis_aresetn,
   chk_axis_rx_if.slave rx_axis,
   input  logic         input_pkts_done,
   input  logic [63:0]  expected_good,
   input  logic [63:0]  expected_bad,
   output logic [63:0]  good_pkts,
   output logic [63:0]  bad_pkts,
   output logic [63:0]  err_pkts,
   output logic [63:0]  rx_bytes,
   output logic         check_done,
   output logic         check_pass
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FRAME = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
   localparam logic [31:0] IDLE_TO = 32'(IDLE_TIMEOUT);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic        perr_q, perr_d;
   logic        in_frame_q, in_frame_d;
   logic [31:0] idle_q, idle_d;
   logic [63:0] good_q, good_d;
   logic [63:0] bad_q, bad_d;
   logic [63:0] err_q, err_d;
   logic [63:0] bytes_q, bytes_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;

   logic        rst_eff;
   logic [3:0]  keep_cnt;
   logic [16:0] len_sum;
   logic [15:0] len_new;
   logic        last_keep_ok;
   logic        keep_err;
   logic        perr_new;
   logic        len_bad;
   logic        beat;
   logic        mid_frame;
   logic        counts_match;
   logic        timed_out;
   logic        unused_tdata;

   // Any of the three reset sources holds the whole checker in reset.
   assign rst_eff = reset | ~rx_dcm_locked | ~rx_axis_aresetn;

   // Payload content is not checked, only framing and length.
   assign unused_tdata = ^rx_axis.tdata;

   // Saturating byte count including the current beat.
   assign keep_cnt = 4'($countones(rx_axis.tkeep));
   assign len_sum  = {1'b0, len_q} + {13'd0, keep_cnt};
   assign len_new  = len_sum[16] ? 16'hFFFF : len_sum[15:0];

   // Last beat must be a contiguous low-byte run; earlier beats must be full.
   assign last_keep_ok = rx_axis.tkeep inside {8'h01, 8'h03, 8'h07, 8'h0F,
                                               8'h1F, 8'h3F, 8'h7F, 8'hFF};
   assign keep_err = rx_axis.tlast ? ~last_keep_ok : (rx_axis.tkeep != 8'hFF);
   assign perr_new = perr_q | keep_err;
   assign len_bad  = (len_new < MIN_L) | (len_new > MAX_L);

   // Beats after the verdict are ignored by the statistics.
   assign beat = rx_axis.tvalid & (state_q != S_DONE);

   // A beat on the bus this cycle also counts as an open frame, so the
   // drain exit never races a counter update.
   assign mid_frame    = in_frame_q | rx_axis.tvalid;
   assign counts_match = (good_q + bad_q + err_q) == (expected_good + expected_bad);
   assign timed_out    = idle_q >= IDLE_TO;

   // Next-state, frame accumulation, classification and verdict.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      perr_d     = perr_q;
      in_frame_d = in_frame_q;
      idle_d     = idle_q;
      good_d     = good_q;
      bad_d      = bad_q;
      err_d      = err_q;
      bytes_d    = bytes_q;
      done_d     = done_q;
      pass_d     = pass_q;

      if (beat) begin
         if (rx_axis.tlast) begin
            len_d      = 16'd0;
            perr_d     = 1'b0;
            in_frame_d = 1'b0;
            if (perr_new || len_bad) begin
               err_d = err_q + 64'd1;
            end else if (!rx_axis.tuser) begin
               bad_d = bad_q + 64'd1;
            end else begin
               good_d  = good_q + 64'd1;
               bytes_d = bytes_q + {48'd0, len_new};
            end
         end else begin
            len_d      = len_new;
            perr_d     = perr_new;
            in_frame_d = 1'b1;
         end
      end

      if (rx_axis.tvalid) begin
         idle_d = 32'd0;
      end else if ((state_q == S_DRAIN) && (idle_q != 32'hFFFF_FFFF)) begin
         idle_d = idle_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_axis.tvalid && !rx_axis.tlast) begin
               state_d = S_FRAME;
            end else if (input_pkts_done) begin
               state_d = S_DRAIN;
            end
         end
         S_FRAME: begin
            if (rx_axis.tvalid && rx_axis.tlast) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (!mid_frame && (counts_match || timed_out)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (good_q == expected_good) && (bad_q == expected_bad) &&
                         (err_q == 64'd0);
            end
         end
         S_DONE: begin
            if (rx_axis.tvalid) begin
               pass_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and statistics registers with synchronous effective reset.
   always_ff @(posedge clk) begin
      if (rst_eff) begin
         state_q    <= S_IDLE;
         len_q      <= 16'd0;
         perr_q     <= 1'b0;
         in_frame_q <= 1'b0;
         idle_q     <= 32'd0;
         good_q     <= 64'd0;
         bad_q      <= 64'd0;
         err_q      <= 64'd0;
         bytes_q    <= 64'd0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         perr_q     <= perr_d;
         in_frame_q <= in_frame_d;
         idle_q     <= idle_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         err_q      <= err_d;
         bytes_q    <= bytes_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign good_pkts  = good_q;
   assign bad_pkts   = bad_q;
   assign err_pkts   = err_q;
   assign rx_bytes   = bytes_q;
   assign check_done = done_q;
   assign check_pass = pass_q;

endmodule

// File: tb/tb_chk_axis_rx.sv
// Purpose: directed checks of chk_axis_rx framing, classification, statistics, verdict and reset.
// Latency: per-frame expectations are compared one cycle after each tlast beat.
// Backpressure: none; the bench drives beats freely, as the MAC would.
module tb_chk_axis_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_dcm_locked;
   logic        rx_axis_aresetn;
   logic        input_pkts_done;
   logic [63:0] expected_good;
   logic [63:0] expected_bad;
   logic [63:0] good_pkts;
   logic [63:0] bad_pkts;
   logic [63:0] err_pkts;
   logic [63:0] rx_bytes;
   logic        check_done;
   logic        check_pass;

   chk_axis_rx_if rx_axis();

   chk_axis_rx #(
      .MIN_LEN      (64),
      .MAX_LEN      (1518),
      .IDLE_TIMEOUT (1000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .rx_dcm_locked   (rx_dcm_locked),
      .rx_axis_aresetn (rx_axis_aresetn),
      .rx_axis         (rx_axis),
      .input_pkts_done (input_pkts_done),
      .expected_good   (expected_good),
      .expected_bad    (expected_bad),
      .good_pkts       (good_pkts),
      .bad_pkts        (bad_pkts),
      .err_pkts        (err_pkts),
      .rx_bytes        (rx_bytes),
      .check_done      (check_done),
      .check_pass      (check_pass)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] g;
      logic [63:0] b;
      logic [63:0] e;
      logic [63:0] by;
   } snap_t;

   snap_t       sb[$];
   snap_t       mon_s;
   logic [63:0] m_g, m_b, m_e, m_by;
   bit          frozen;
   int          checks   = 0;
   int          failures = 0;
   logic        pend     = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_good"}, good_pkts, 64'd0);
      chk({tag, "_bad"},  bad_pkts,  64'd0);
      chk({tag, "_err"},  err_pkts,  64'd0);
      chk({tag, "_bytes"}, rx_bytes, 64'd0);
      chk({tag, "_done"}, {63'd0, check_done}, 64'd0);
      chk({tag, "_pass"}, {63'd0, check_pass}, 64'd0);
   endtask

   task automatic model_clear();
      m_g = 64'd0;
      m_b = 64'd0;
      m_e = 64'd0;
      m_by = 64'd0;
      sb.delete();
   endtask

   // Scoreboard monitor: a tlast beat seen on one edge must show its counters after that edge.
   always @(posedge clk) pend <= rx_axis.tvalid & rx_axis.tlast;

   always @(negedge clk) begin
      if (pend) begin
         chk("sb_has_entry", {63'd0, sb.size() > 0}, 64'd1);
         if (sb.size() > 0) begin
            mon_s = sb.pop_front();
            chk("sb_good",  good_pkts, mon_s.g);
            chk("sb_bad",   bad_pkts,  mon_s.b);
            chk("sb_err",   err_pkts,  mon_s.e);
            chk("sb_bytes", rx_bytes,  mon_s.by);
         end
      end
   end

   task automatic send_beat(input logic [7:0] keep, input bit last, input bit user);
      rx_axis.tdata  = {$urandom, $urandom};
      rx_axis.tkeep  = keep;
      rx_axis.tlast  = last;
      rx_axis.tuser  = user;
      rx_axis.tvalid = 1'b1;
      @(negedge clk);
      rx_axis.tvalid = 1'b0;
      rx_axis.tlast  = 1'b0;
   endtask

   // Drives one frame and pushes the counter snapshot the frame should produce.
   task automatic send_frame(input int nbeats, input logic [7:0] last_keep, input bit user,
                             input int bad_idx, input logic [7:0] bad_keep, input int gap);
      int         len  = 0;
      bit         perr = 1'b0;
      logic [7:0] k;
      snap_t      s;
      for (int i = 0; i < nbeats; i++) begin
         if (i == nbeats - 1)  k = last_keep;
         else if (i == bad_idx) k = bad_keep;
         else                   k = 8'hFF;
         len += $countones(k);
         if (i == nbeats - 1) begin
            if (!(k inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF}))
               perr = 1'b1;
            if (!frozen) begin
               if (perr || len < 64 || len > 1518) m_e++;
               else if (!user)                     m_b++;
               else begin
                  m_g++;
                  m_by += 64'(len);
               end
            end
            s.g = m_g; s.b = m_b; s.e = m_e; s.by = m_by;
            sb.push_back(s);
            send_beat(k, 1'b1, user);
         end else begin
            if (k != 8'hFF) perr = 1'b1;
            send_beat(k, 1'b0, ~user);
            repeat (gap) @(negedge clk);
         end
      end
   endtask

   initial begin
      reset           = 1'b1;
      rx_dcm_locked   = 1'b1;
      rx_axis_aresetn = 1'b1;
      input_pkts_done = 1'b0;
      expected_good   = 64'd0;
      expected_bad    = 64'd0;
      rx_axis.tdata   = 64'd0;
      rx_axis.tkeep   = 8'd0;
      rx_axis.tvalid  = 1'b0;
      rx_axis.tlast   = 1'b0;
      rx_axis.tuser   = 1'b0;
      frozen          = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_zero("reset");

      // Framing, length and MAC-status classification.
      send_frame(8, 8'hFF, 1'b1, -1, 8'h00, 0);      // 64B good
      repeat (2) @(negedge clk);
      send_frame(8, 8'h1F, 1'b1, -1, 8'h00, 0);      // 61B runt
      send_frame(190, 8'h3F, 1'b1, -1, 8'h00, 0);    // 1518B good, back-to-back
      send_frame(190, 8'h7F, 1'b1, -1, 8'h00, 0);    // 1519B too long
      send_frame(8, 8'h7F, 1'b1, -1, 8'h00, 0);      // 63B runt
      send_frame(8, 8'hFF, 1'b0, -1, 8'h00, 0);      // MAC bad
      send_frame(8, 8'hFF, 1'b1, 2, 8'h7F, 0);       // partial mid beat
      send_frame(9, 8'h05, 1'b1, -1, 8'h00, 0);      // non-contiguous last keep
      send_frame(16, 8'hFF, 1'b1, -1, 8'h00, 3);     // 128B with gaps
      send_frame(1, 8'hFF, 1'b1, -1, 8'h00, 0);      // single-beat runt
      repeat (3) @(negedge clk);

      // Reset mid-frame discards the partial frame.
      send_beat(8'hFF, 1'b0, 1'b0);
      send_beat(8'hFF, 1'b0, 1'b0);
      send_beat(8'hFF, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      chk_zero("rst_mid");
      send_frame(8, 8'hFF, 1'b1, -1, 8'h00, 0);
      @(negedge clk);

      // Stream reset mid-frame.
      send_beat(8'hFF, 1'b0, 1'b0);
      send_beat(8'hFF, 1'b0, 1'b0);
      rx_axis_aresetn = 1'b0;
      @(negedge clk);
      rx_axis_aresetn = 1'b1;
      model_clear();
      chk_zero("aresetn_mid");
      send_frame(8, 8'hFF, 1'b1, -1, 8'h00, 0);
      @(negedge clk);

      // End of test by count match.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      expected_good   = 64'd3;
      expected_bad    = 64'd1;
      input_pkts_done = 1'b1;
      @(negedge clk);
      send_frame(8, 8'hFF, 1'b1, -1, 8'h00, 0);
      repeat (2) @(negedge clk);
      send_frame(12, 8'hFF, 1'b1, -1, 8'h00, 1);
      repeat (2) @(negedge clk);
      send_frame(8, 8'hFF, 1'b0, -1, 8'h00, 0);
      repeat (2) @(negedge clk);
      send_frame(10, 8'h0F, 1'b1, -1, 8'h00, 0);
      chk("match_done_early", {63'd0, check_done}, 64'd0);
      @(negedge clk);
      chk("match_done", {63'd0, check_done}, 64'd1);
      chk("match_pass", {63'd0, check_pass}, 64'd1);
      repeat (3) @(negedge clk);
      frozen = 1'b1;
      send_frame(1, 8'hFF, 1'b1, -1, 8'h00, 0);
      frozen = 1'b0;
      chk("late_beat_done", {63'd0, check_done}, 64'd1);
      chk("late_beat_pass", {63'd0, check_pass}, 64'd0);
      repeat (2) @(negedge clk);
      chk("late_beat_pass_sticky", {63'd0, check_pass}, 64'd0);

      // End of test by idle timeout.
      input_pkts_done = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      chk_zero("rst_timeout");
      expected_good   = 64'd4;
      expected_bad    = 64'd1;
      input_pkts_done = 1'b1;
      @(negedge clk);
      send_frame(8, 8'hFF, 1'b1, -1, 8'h00, 0);
      send_frame(8, 8'hFF, 1'b1, -1, 8'h00, 0);
      @(negedge clk);
      send_frame(8, 8'hFF, 1'b0, -1, 8'h00, 0);
      send_frame(8, 8'hFF, 1'b1, -1, 8'h00, 0);
      repeat (1000) @(negedge clk);
      chk("timeout_done_early", {63'd0, check_done}, 64'd0);
      @(negedge clk);
      chk("timeout_done", {63'd0, check_done}, 64'd1);
      chk("timeout_pass", {63'd0, check_pass}, 64'd0);

      repeat (2) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/chk_axis_rx.md
# chk_axis_rx

Receive-side packet checker that consumes the 64-bit RX AXI4-Stream output of the 10G MAC in simulation and testbench-on-FPGA setups. It reassembles beats into frames, validates tkeep framing and frame length, classifies each frame as good, MAC-flagged bad, or erroneous, and accumulates statistics. Once the TX stimulus reports completion, it declares end of test and a pass/fail verdict against the stimulus packet counts.

## Interface
- MIN_LEN, 64: minimum legal frame length in bytes.
- MAX_LEN, 1518: maximum legal frame length in bytes.
- IDLE_TIMEOUT, 1000: number of idle cycles after input_pkts_done before forcing done.
- clk  in  1  RX clock.
- reset  in  1  synchronous, active-high.
- rx_dcm_locked  in  1  low holds block in reset.
- rx_axis_aresetn  in  1  low holds block in reset.
- rx_axis_tdata  in  64  beat data; byte 0 in [7:0].
- rx_axis_tkeep  in  8  byte enables.
- rx_axis_tvalid  in  1  beat valid. No tready; every valid beat is consumed.
- rx_axis_tlast  in  1  last beat of frame.
- rx_axis_tuser  in  1  sampled on tlast beat only; 1 = MAC reports good frame.
- input_pkts_done  in  1  TX stimulus finished, level.
- expected_good  in  64  count of frames the stimulus completed.
- expected_bad  in  64  count of frames the stimulus aborted.
- good_pkts  out  64  frames passing all checks with tuser=1.
- bad_pkts  out  64  frames with tuser=0 and no protocol error.
- err_pkts  out  64  protocol or length violations.
- rx_bytes  out  64  sum of lengths of good frames.
- check_done  out  1  verdict valid, sticky.
- check_pass  out  1  verdict; meaningful only when check_done=1.

## Operation
- Effective reset = reset | !rx_dcm_locked | !rx_axis_aresetn. All outputs reset to 0. FSM enters S_IDLE, and the frame length and flags clear.
- FSM states:
  - S_IDLE: between frames. A valid beat starts a frame: the beat is processed and the FSM goes to S_FRAME, or stays in S_IDLE if tlast=1 on that beat (single-beat frame).
  - S_FRAME: frame in progress. tvalid=0 gaps are allowed, and state holds. A valid beat with tlast=1 closes the frame and returns to S_IDLE.
  - S_DRAIN: entered from S_IDLE when input_pkts_done=1. Frames arriving here are processed identically. Exit to S_DONE when not mid-frame and either good+bad+err == expected_good+expected_bad, or the idle counter reaches IDLE_TIMEOUT.
  - S_DONE: terminal until reset.
- Beat checks:
  - A non-last beat needs tkeep == 8'hFF.
  - A last beat needs tkeep in {01,03,07,0F,1F,3F,7F,FF}.
  - Any violation sets the frame's proto_err flag.
- Frame length is a 16-bit byte counter that adds popcount(tkeep) per beat and saturates at 16'hFFFF.
- Classification on the tlast beat, in priority order:
  1. proto_err, or length < MIN_LEN, or length > MAX_LEN → err_pkts+1.
  2. Otherwise tuser=0 → bad_pkts+1.
  3. Otherwise → good_pkts+1 and rx_bytes += length.
- Idle counter (32 bits):
  - Counts cycles with tvalid=0 while in S_DRAIN.
  - Clears on any valid beat.
  - Saturates.
- Verdict on entry to S_DONE: check_pass = (good_pkts==expected_good) & (bad_pkts==expected_bad) & (err_pkts==0).
- A valid beat while in S_DONE clears check_pass, which stays cleared. Counters do not update in S_DONE.
- Statistics counters wrap modulo 2^64; no overflow flag.

## Timing
- All outputs are registered.
- Counters and rx_bytes update on the cycle after the tlast beat is sampled.
- Back-to-back frames are supported at full rate: a new first beat may follow a tlast beat on the next cycle with no dead cycle.
- The S_DRAIN exit condition is evaluated on registered counter values. check_done and check_pass rise together one cycle after the condition is true.
- A count-match exit must not fire while a frame is open: the FSM waits for tlast.
- input_pkts_done arriving mid-frame takes effect after that frame's tlast.
- Effective reset mid-frame discards the partial frame without counting it. Outputs are 0 on the cycle after reset is sampled.

## Test plan
- Good 64-byte frame: 8 beats, tkeep FF on every beat, tuser=1 on last → good_pkts=1, rx_bytes=64, other counters 0.
- Runt frame: 61 bytes, 8 beats with last tkeep=8'h1F, tuser=1 → err_pkts=1, rx_bytes unchanged. Then a 1518-byte good frame sent back-to-back → good_pkts=1, rx_bytes=1518.
- Protocol and MAC errors:
  - 64-byte frame with tuser=0 on last → bad_pkts=1.
  - Frame with a non-last beat tkeep=8'h7F → err_pkts=1 even with tuser=1.
  - Last beat tkeep=8'h05 → err_pkts=1.
- Gaps and single-beat frame: tvalid=0 gaps of 3 cycles inside a 128-byte good frame → good_pkts=1, rx_bytes=128. Single-beat tlast frame with tkeep=FF → err_pkts=1.
- End of test:
  - expected_good=3, expected_bad=1, input_pkts_done=1. After 3 good frames and 1 tuser=0 frame, check_done=1 and check_pass=1 one cycle after the last counter update.
  - Repeat with expected_good=4 and only 3 good frames → check_done after IDLE_TIMEOUT idle cycles with check_pass=0.
  - A beat arriving after done clears check_pass.
- Reset: assert reset, or drop rx_axis_aresetn, mid-frame → all outputs 0. The next complete 64-byte good frame yields good_pkts=1 with no residue from the partial frame.
